// File: rtl/vram_writer_pkg.sv
// Shared constants and types for the VRAM write-side master.
// Holds the VRAM address map, request payload layout and FSM encodings.
package vram_writer_pkg;

    localparam int unsigned VRAM_ADDR_WIDTH = 12;
    localparam int unsigned ADDR_CNT_WIDTH  = VRAM_ADDR_WIDTH + 1;
    localparam int unsigned DATA_WIDTH      = 8;
    localparam int unsigned LEN_WIDTH       = 12;

    // Region map: PMF, PMB, NTBL, OBM; everything at or above VRAM_SIZE is unmapped
    localparam logic [VRAM_ADDR_WIDTH-1:0] PMF_BASE  = 12'h000;
    localparam logic [VRAM_ADDR_WIDTH-1:0] PMB_BASE  = 12'h200;
    localparam logic [VRAM_ADDR_WIDTH-1:0] NTBL_BASE = 12'h400;
    localparam logic [VRAM_ADDR_WIDTH-1:0] OBM_BASE  = 12'h800;
    localparam int unsigned VRAM_SIZE_DEFAULT = 2304;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    // One queued request: 1 + 12 + 8 + 12 = 33 bits
    typedef struct packed {
        logic                       fill;
        logic [VRAM_ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]      data;
        logic [LEN_WIDTH-1:0]       length;
    } vram_req_t;

endpackage

// File: rtl/vram_req_fifo.sv
// Synchronous request FIFO; full/empty derived from pointers carrying a wrap bit.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data (head, valid
// while !empty), full, empty. Push when full and pop when empty are ignored.
module vram_req_fifo
    import vram_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  vram_req_t push_data,
    input  logic      pop,
    output vram_req_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    vram_req_t          mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // Pointer update; a pop on a full FIFO frees its slot for the next cycle only
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; entries are only read behind the write pointer
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/vram_writer.sv
// VRAM write-side master: queues CPU byte-write/fill requests and drains them onto
// the GPU VRAM port as one-cycle cs strobes while write_window (vblank) is open.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_fill/req_address/
// req_data/req_length request side; write_window; vram_data/vram_address/vram_cs
// to GPU; busy; range_err (sticky) with err_clear.
module vram_writer
    import vram_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned VRAM_SIZE  = VRAM_SIZE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_fill,
    input  logic [VRAM_ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]      req_data,
    input  logic [LEN_WIDTH-1:0]       req_length,
    input  logic                       write_window,
    output logic [DATA_WIDTH-1:0]      vram_data,
    output logic [VRAM_ADDR_WIDTH-1:0] vram_address,
    output logic                       vram_cs,
    output logic                       busy,
    output logic                       range_err,
    input  logic                       err_clear
);

    localparam logic [ADDR_CNT_WIDTH-1:0] SIZE_LIMIT = ADDR_CNT_WIDTH'(VRAM_SIZE);

    state_t                      state;
    logic [ADDR_CNT_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]       cur_data;
    logic [LEN_WIDTH-1:0]        remaining;
    vram_req_t                   in_req;
    vram_req_t                   head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        in_range;

    assign in_req    = '{fill: req_fill, address: req_address, data: req_data, length: req_length};
    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);
    assign in_range  = (cur_addr < SIZE_LIMIT);

    vram_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (in_req),
        .pop       (state == ST_IDLE),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Request sequencer, address counter, error flag and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur_addr     <= '0;
            cur_data     <= '0;
            remaining    <= '0;
            vram_cs      <= 1'b0;
            vram_data    <= '0;
            vram_address <= '0;
            range_err    <= 1'b0;
        end else begin
            vram_cs <= 1'b0;
            if (err_clear) range_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_addr  <= {1'b0, head.address};
                        cur_data  <= head.data;
                        remaining <= head.fill ? head.length : '0;
                        state     <= head.fill ? ST_FILL : ST_SINGLE;
                    end
                end
                ST_SINGLE, ST_FILL: begin
                    // Closed window holds everything, so resuming neither repeats nor skips
                    if (write_window) begin
                        vram_address <= cur_addr[VRAM_ADDR_WIDTH-1:0];
                        vram_data    <= cur_data;
                        // Out-of-range bytes are consumed silently; set beats a same-cycle clear
                        if (in_range) vram_cs   <= 1'b1;
                        else          range_err <= 1'b1;
                        cur_addr  <= cur_addr + ADDR_CNT_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if ((state == ST_SINGLE) || (remaining == '0)) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
